// File: rtl/mm_mac_sched.sv
// Operand issue and result write-back sequencer for a LANES-wide MAC matrix multiply (C = A*B).
// Define MM_SCHED_PERF_EN to build the clk_count/stall_count performance counters.
module mm_mac_sched #(
  parameter int DIM     = 8,
  parameter int LANES   = 2,
  parameter int AW      = 6,
  parameter int DW      = 19,
  parameter int MAC_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic [AW-1:0]         a_addr,
  output logic [AW-1:0]         b_addr,
  output logic                  mac_en,
  output logic                  mac_first,
  input  logic [LANES*DW-1:0]   mac_out,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [10:0]           clk_count,
  output logic [10:0]           stall_count
);

  localparam int NG = DIM / LANES;
  localparam int KW = $clog2(DIM);
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [KW-1:0] j_cnt, k_cnt;
  logic [GW-1:0] g_cnt;
  logic          issue, last_k, last_g, last_j, final_issue, enter;
  logic [AW-1:0] group_base;

  logic [MAC_LAT-1:0] tag_pipe;
  logic [AW-1:0]      base_pipe [MAC_LAT];
  logic               capture, pipe_empty;

  logic [LANES*DW-1:0] wbuf;
  logic [AW-1:0]       wbase;
  logic [CW-1:0]       wcnt;

  assign issue       = (state == RUN) && !hold;
  assign last_k      = (k_cnt == KW'(DIM - 1));
  assign last_g      = (g_cnt == GW'(NG - 1));
  assign last_j      = (j_cnt == KW'(DIM - 1));
  assign final_issue = issue && last_k && last_g && last_j;
  assign enter       = start && ((state == IDLE) || (state == DONE));
  assign group_base  = AW'(j_cnt) * AW'(DIM) + AW'(g_cnt) * AW'(LANES);
  assign capture     = tag_pipe[MAC_LAT-1];
  assign pipe_empty  = (tag_pipe == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (final_issue) state_nxt = DRAIN;
      DRAIN: if (pipe_empty && (wcnt <= CW'(1))) state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mac_en    = issue;
    mac_first = issue && (k_cnt == '0);
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
  end

  // Loop order j (column) / g (lane group) / k (term); counters freeze while hold is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j_cnt <= '0;
      g_cnt <= '0;
      k_cnt <= '0;
    end else if (enter) begin
      j_cnt <= '0;
      g_cnt <= '0;
      k_cnt <= '0;
    end else if (issue) begin
      if (last_k) begin
        k_cnt <= '0;
        if (last_g) begin
          g_cnt <= '0;
          j_cnt <= j_cnt + KW'(1);
        end else begin
          g_cnt <= g_cnt + GW'(1);
        end
      end else begin
        k_cnt <= k_cnt + KW'(1);
      end
    end
  end

  assign a_addr = AW'(k_cnt) * AW'(DIM) + AW'(g_cnt) * AW'(LANES);
  assign b_addr = AW'(j_cnt) * AW'(DIM) + AW'(k_cnt);

  // Last-term tag and its result base address ride alongside the MAC latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_pipe <= '0;
      for (int i = 0; i < MAC_LAT; i++) base_pipe[i] <= '0;
    end else begin
      tag_pipe[0]  <= issue && last_k;
      base_pipe[0] <= group_base;
      for (int i = 1; i < MAC_LAT; i++) begin
        tag_pipe[i]  <= tag_pipe[i-1];
        base_pipe[i] <= base_pipe[i-1];
      end
    end
  end

  // Write buffer: lane 0 sits in the LSBs and is shifted out one lane per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbuf  <= '0;
      wbase <= '0;
      wcnt  <= '0;
    end else if (capture) begin
      wbuf  <= mac_out;
      wbase <= base_pipe[MAC_LAT-1];
      wcnt  <= CW'(LANES);
    end else if (wcnt != '0) begin
      wbuf  <= wbuf >> DW;
      wbase <= wbase + AW'(1);
      wcnt  <= wcnt - CW'(1);
    end
  end

  assign wr_en   = (wcnt != '0);
  assign wr_addr = wbase;
  assign wr_data = wbuf[DW-1:0];

`ifdef MM_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_count   <= '0;
      stall_count <= '0;
    end else if (enter) begin
      clk_count   <= '0;
      stall_count <= '0;
    end else begin
      if (busy && (clk_count != 11'h7FF))
        clk_count <= clk_count + 11'd1;
      if ((state == RUN) && hold && (stall_count != 11'h7FF))
        stall_count <= stall_count + 11'd1;
    end
  end
`else
  assign clk_count   = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mm_mac_sched.sv
// Scoreboard bench for mm_mac_sched: a behavioural MAC array and A/B RAMs drive the DUT,
// expected writes are queued at start and a negedge monitor checks address, data and cycle.
module tb_mm_mac_sched;

  localparam int DIM   = 8;
  localparam int LANES = 2;
  localparam int AW    = 6;
  localparam int DW    = 19;

  logic                clk;
  logic                reset;
  logic                start;
  logic                hold;
  logic [AW-1:0]       a_addr, b_addr, wr_addr;
  logic                mac_en, mac_first, wr_en, busy, done;
  logic [LANES*DW-1:0] mac_out;
  logic [DW-1:0]       wr_data;
  logic [10:0]         clk_count, stall_count;

  mm_mac_sched #(.DIM(DIM), .LANES(LANES), .AW(AW), .DW(DW), .MAC_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en), .mac_first(mac_first),
    .mac_out(mac_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .clk_count(clk_count), .stall_count(stall_count)
  );

  typedef struct {
    int     addr;
    longint data;
    int     cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run0 = 0;

  logic signed [7:0]    amem [DIM*DIM];
  logic signed [7:0]    bmem [DIM*DIM];
  logic signed [DW-1:0] acc  [LANES];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Registered MAC lanes sharing the B operand (one cycle of latency).
  always @(posedge clk) begin
    logic signed [15:0] p;
    if (mac_en) begin
      for (int l = 0; l < LANES; l++) begin
        p = amem[int'(a_addr) + l] * bmem[b_addr];
        acc[l] <= mac_first ? DW'(p) : acc[l] + DW'(p);
      end
    end
  end

  always_comb begin
    mac_out = '0;
    for (int l = 0; l < LANES; l++) mac_out[l*DW +: DW] = acc[l];
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d expected no write", wr_addr);
      end else begin
        e = q.pop_front();
        checkOutput("wr_addr", longint'(wr_addr), longint'(e.addr));
        checkOutput("wr_data", longint'($signed(wr_data)), e.data);
        checkOutput("wr_cycle", longint'(cyc - run0), longint'(e.cyc));
      end
    end
  end

  // Queue all 64 expected writes, then pulse start; run0 marks RUN cycle 0.
  task automatic applyStimulus(input bit data_is_addr, input longint cval,
                               input int hold_from, input int hold_len);
    exp_t x;
    for (int w = 0; w < DIM*DIM; w++) begin
      int n;
      n = w / LANES;
      x.addr = w;
      x.data = data_is_addr ? longint'(w) : cval;
      x.cyc  = DIM*n + DIM + 1 + (w % LANES);
      if (hold_len > 0 && hold_from <= DIM*n + DIM - 1) x.cyc += hold_len;
      q.push_back(x);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run0 = cyc;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < run0 + n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int exp_cyc, input int exp_clk, input int exp_stall);
    bit seen;
    int want_clk, want_stall;
    seen = 1'b0;
`ifdef MM_SCHED_PERF_EN
    want_clk   = exp_clk;
    want_stall = exp_stall;
`else
    want_clk   = 0;
    want_stall = 0;
`endif
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      checkOutput("done_cycle", longint'(cyc - run0), longint'(exp_cyc));
      checkOutput("done_busy", longint'(busy), 0);
      checkOutput("clk_count", longint'(clk_count), longint'(want_clk));
      checkOutput("stall_count", longint'(stall_count), longint'(want_stall));
    end
    checkOutput("writes_left", longint'(q.size()), 0);
  endtask

  task automatic check_all_zero(input string name);
    checkOutput(name, longint'({a_addr, b_addr, mac_en, mac_first, wr_en, wr_addr,
                                wr_data, busy, done, clk_count, stall_count}), 0);
  endtask

  task automatic load_identity();
    for (int i = 0; i < DIM*DIM; i++) begin
      amem[i] = ((i % DIM) == (i / DIM)) ? 8'sd1 : 8'sd0;
      bmem[i] = 8'(i);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    load_identity();

    // Reset held with start toggling, then released with start low.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start = ~start;
      @(negedge clk);
      check_all_zero("reset_outputs");
    end
    @(posedge clk); #1 start = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("idle_outputs");
    end

    $display("[TB] identity run");
    applyStimulus(1'b1, 0, 0, 0);
    @(negedge clk);
    checkOutput("run0_mac_first", longint'({mac_en, mac_first, busy}), 7);
    wait_done(259, 259, 0);

    $display("[TB] identity run with hold in cycles 20-24");
    applyStimulus(1'b1, 0, 20, 5);
    goto_cycle(20);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_mac_en", longint'({mac_en, mac_first}), 0);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    wait_done(264, 264, 5);

    $display("[TB] start ignored mid-run, restart from DONE");
    applyStimulus(1'b1, 0, 0, 0);
    goto_cycle(50);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(259, 259, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("done_holds", longint'(done), 1);
    end
    applyStimulus(1'b1, 0, 0, 0);
    @(negedge clk);
    checkOutput("done_clears", longint'({done, busy}), 1);
    wait_done(259, 259, 0);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b1, 0, 0, 0);
    goto_cycle(100);
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    check_all_zero("midrun_reset");
    @(negedge clk);
    check_all_zero("midrun_reset_held");
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
    applyStimulus(1'b1, 0, 0, 0);
    wait_done(259, 259, 0);

    $display("[TB] extreme operands");
    for (int i = 0; i < DIM*DIM; i++) begin
      amem[i] = -8'sd128;
      bmem[i] = -8'sd128;
    end
    applyStimulus(1'b0, 131072, 0, 0);
    wait_done(259, 259, 0);
    for (int i = 0; i < DIM*DIM; i++) bmem[i] = 8'sd127;
    applyStimulus(1'b0, -130048, 0, 0);
    wait_done(259, 259, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_mac_sched.md
# mm_mac_sched

Operand and write-back sequencer for the multi-lane MAC matrix-multiply datapath. It computes C = A·B for DIM×DIM signed 8-bit matrices stored column-major in A/B RAMs. Each cycle it issues one A/B address pair to LANES MAC units that share the B operand. It then captures the lane accumulators and serialises them into the single-port result RAM, one write per cycle. It replaces ad-hoc counter logic inside the top-level FSM with one reusable, stall-aware controller.

## Interface
- DIM, 8, matrix dimension; a power of two, ≥ LANES.
- LANES, 2, parallel MAC lanes; a power of two dividing DIM.
- AW, 6, address width, log2(DIM·DIM).
- DW, 19, MAC accumulator / result width, signed.
- MAC_LAT, 1, cycles from operand issue to the accumulated value appearing on mac_out.

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a multiply; sampled in IDLE and DONE only
- hold  in  1  stall operand issue while high
- a_addr  out  AW  A address for lane 0; lane l reads a_addr+l
- b_addr  out  AW  B address, shared by all lanes
- mac_en  out  1  operands valid this cycle; MACs accumulate
- mac_first  out  1  first term of a dot product; MAC loads product instead of accumulating
- mac_out  in  LANES·DW  lane accumulators, lane 0 in LSBs
- wr_en  out  1  result RAM write strobe
- wr_addr  out  AW  result address, column-major
- wr_data  out  DW  result value
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- clk_count  out  11  cycles spent in RUN+DRAIN
- stall_count  out  11  RUN cycles with hold high

## Operation
- States: IDLE, RUN, DRAIN, DONE. The reset state is IDLE.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DRAIN after the final issue.
  - DRAIN→DONE when the capture pipeline and write buffer are empty.
  - DONE→RUN on start; otherwise DONE holds.
  - start in RUN or DRAIN is ignored.
- Loop order: j (output column) outermost, g (lane group, 0..DIM/LANES−1) middle, k (0..DIM−1) inner.
- Each RUN cycle with hold low issues one term:
  - a_addr = k·DIM + g·LANES
  - b_addr = j·DIM + k
  - mac_en = 1
  - mac_first = (k==0)
- hold high in RUN: mac_en=0, mac_first=0. Loop counters freeze and addresses hold their values. Write-back continues.
- A last-term tag shifts through a MAC_LAT-deep pipeline. When it emerges, all LANES mac_out values are latched into the write buffer.
- The write buffer emits lane 0..LANES−1 on consecutive cycles:
  - wr_addr = j·DIM + g·LANES + l
  - wr_data = the lane value, unmodified (DW signed; no saturation or truncation)
- Buffer overflow is impossible: captures are ≥DIM issue cycles apart and a drain takes LANES ≤ DIM cycles.
- Sampling on the tag cycle reads each group's value before the next group's mac_first overwrites it.

## Timing
- Reset values of all outputs are 0: addresses, mac_en, mac_first, wr_en, wr_addr, wr_data, busy, done, clk_count, stall_count. The state is IDLE.
- RUN is entered the cycle after start. RUN cycle 0 issues (j=0, g=0, k=0).
- With MAC_LAT=1 and no hold, DIM=8, LANES=2:
  - group 0 issues in cycles 0–7; capture in cycle 8; writes in cycles 9 and 10
  - final issue in cycle 255; final writes in cycles 257 and 258
  - done rises in cycle 259 with clk_count=259
  - total writes: 64
- Each hold cycle in RUN delays done by one cycle and increments stall_count.
- clk_count and stall_count saturate at 2047. Both clear on the RUN entry cycle.
- done is a level. It clears in the cycle RUN is re-entered.
- An asynchronous reset mid-run returns the block to reset values immediately. Partial results already written are not retracted.

## Configuration
- MM_SCHED_PERF_EN defined: the clk_count and stall_count counters are implemented as specified.
- MM_SCHED_PERF_EN undefined: no counter logic is implemented. clk_count and stall_count are tied to 0. All other behaviour and timing are identical.

## Test plan
- Hold reset low with start toggling → every output stays 0; the state stays IDLE.
- A = identity, B[n] = n (column-major), start, hold=0 → 64 writes, with wr_data equal to wr_addr for every address 0..63. Address order: 0,1 at cycles 9,10, then 2,3 at 17,18. done at cycle 259; clk_count=259.
- Same as the previous case, plus hold=1 during RUN cycles 20–24 → mac_en=0 for those 5 cycles, identical write data, done at cycle 264, stall_count=5.
- Pulse start at RUN cycle 50, then pulse start again in DONE → the first pulse is ignored. The second pulse clears done the next cycle and a full second run repeats the 64 writes.
- Pull reset low at RUN cycle 100, release, then start → outputs are 0 during reset. A clean 64-write run follows, starting at wr_addr 0.
- A all −128, B all −128 → every wr_data = 131072. A all −128, B all 127 → every wr_data = −130048. No wrap in 19 bits.
